// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// 32-bit program counter for the MIMA RV32 fetch stage. The register holds the
// address of the instruction being fetched. On every rising clock edge it
// either steps to the next sequential instruction, loads an absolute jump
// target, or adds a signed offset to the current value.
//
// Ports:
//   clk  in   1   system clock; all state changes on the rising edge
//   rst  in   1   synchronous, active-high reset; loads RESET_VECTOR
//   jmp  in   1   jump request for the current cycle
//   rel  in   1   qualifies jmp: 1 = cur + nxt, 0 = nxt (ignored when jmp=0)
//   nxt  in  32   absolute target, or two's-complement offset when rel=1
//   cur  out 32   current PC, driven straight from the state register
//
// Parameters:
//   RESET_VECTOR  address loaded by reset
//   STEP          sequential increment in bytes (one RV32 instruction)
//
// All arithmetic is modulo 2^32. Wrap-around in either direction is legal, and
// there is no alignment masking: a misaligned target is passed through
// untouched so the trap logic downstream can see it.
// -----------------------------------------------------------------------------
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] STEP         = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp,
  input  logic        rel,
  input  logic [31:0] nxt,
  output logic [31:0] cur
);

  // Where the next PC value comes from. Naming the choice keeps the priority
  // ordering readable and separates it from the datapath arithmetic.
  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_SEQ   = 2'd1,
    SRC_ABS   = 2'd2,
    SRC_REL   = 2'd3
  } pc_src_e;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] seq_addr;
  logic [31:0] rel_addr;
  pc_src_e     pc_src;

  // Both adders are plain 32-bit adds. A carry out of bit 31 is simply
  // dropped, which gives the required wrap-around. A negative offset is just a
  // large unsigned addend, so backward jumps need no special handling.
  assign seq_addr = pc_q + STEP;
  assign rel_addr = pc_q + nxt;

  // Priority: reset over jump, and jump over sequential. rel only has an
  // effect when jmp is set.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch. A missing assignment on some path would infer a latch.
    pc_src = SRC_SEQ;
    if (rst) begin
      pc_src = SRC_RESET;
    end else if (jmp) begin
      pc_src = rel ? SRC_REL : SRC_ABS;
    end
  end

  always_comb begin
    pc_d = seq_addr;
    unique case (pc_src)
      SRC_RESET: pc_d = RESET_VECTOR;
      SRC_SEQ:   pc_d = seq_addr;
      SRC_ABS:   pc_d = nxt;
      SRC_REL:   pc_d = rel_addr;
    endcase
  end

  // Reset is synchronous, so it is just the highest-priority source in the
  // next-state mux above, and the register itself is a plain flop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment. Every flop then
    // samples its pre-edge inputs, so a relative jump adds nxt to the old PC.
    pc_q <= pc_d;
  end

  // cur comes straight from the register. No input reaches it without first
  // passing through a clock edge.
  assign cur = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//
// Directed bench for program_counter. Each task drives one scenario and checks
// cur against hand-computed addresses. Inputs change 1 ns after a rising edge,
// and cur is sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        jmp;
  logic        rel;
  logic [31:0] nxt;
  logic [31:0] cur;

  int total;
  int bad;

  program_counter #(
    .RESET_VECTOR(32'h0000_0000),
    .STEP        (32'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jmp(jmp),
    .rel(rel),
    .nxt(nxt),
    .cur(cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a run that never finishes.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge, then settle 1 ns before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jmp = 1'b0; rel = 1'b0; nxt = 32'h0;
    tick();
    total++;
    if (cur !== 32'h0000_0000) begin
      bad++;
      $display("FAIL reset_value: got %h expected %h", cur, 32'h0000_0000);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (cur !== 32'(4 * i)) begin
        bad++;
        $display("FAIL reset_seq[%0d]: got %h expected %h", i, cur, 32'(4 * i));
      end
    end
  endtask

  task automatic test_abs_jump();
    jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_1000;
    tick();
    total++;
    if (cur !== 32'h0000_1000) begin
      bad++;
      $display("FAIL abs_jump: got %h expected %h", cur, 32'h0000_1000);
    end
    jmp = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (cur !== 32'h0000_1000 + 32'(4 * i)) begin
        bad++;
        $display("FAIL abs_seq[%0d]: got %h expected %h", i, cur, 32'h0000_1000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_rel_backward();
    // cur is 0x1014 here; -20 brings it back to 0x1000.
    jmp = 1'b1; rel = 1'b1; nxt = 32'hFFFF_FFEC;
    tick();
    total++;
    if (cur !== 32'h0000_1000) begin
      bad++;
      $display("FAIL rel_back: got %h expected %h", cur, 32'h0000_1000);
    end
    jmp = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (cur !== 32'h0000_1000 + 32'(4 * i)) begin
        bad++;
        $display("FAIL rel_back_seq[%0d]: got %h expected %h", i, cur, 32'h0000_1000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_rel_forward_zero();
    jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_0100;
    tick();
    total++;
    if (cur !== 32'h0000_0100) begin
      bad++;
      $display("FAIL fwd_setup: got %h expected %h", cur, 32'h0000_0100);
    end
    rel = 1'b1; nxt = 32'h0000_0010;
    tick();
    total++;
    if (cur !== 32'h0000_0110) begin
      bad++;
      $display("FAIL rel_forward: got %h expected %h", cur, 32'h0000_0110);
    end
    nxt = 32'h0000_0000;
    tick();
    total++;
    if (cur !== 32'h0000_0110) begin
      bad++;
      $display("FAIL rel_zero: got %h expected %h", cur, 32'h0000_0110);
    end
    jmp = 1'b0;
    tick();
    total++;
    if (cur !== 32'h0000_0114) begin
      bad++;
      $display("FAIL rel_zero_resume: got %h expected %h", cur, 32'h0000_0114);
    end
  endtask

  task automatic test_wrap();
    jmp = 1'b1; rel = 1'b0; nxt = 32'hFFFF_FFF8;
    tick();
    total++;
    if (cur !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL wrap_setup: got %h expected %h", cur, 32'hFFFF_FFF8);
    end
    jmp = 1'b0;
    tick();
    total++;
    if (cur !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_seq1: got %h expected %h", cur, 32'hFFFF_FFFC);
    end
    tick();
    total++;
    if (cur !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_seq2: got %h expected %h", cur, 32'h0000_0000);
    end
    // Back to 0xFFFF_FFFC, then a relative +8 wraps forward to 0x4.
    jmp = 1'b1; rel = 1'b0; nxt = 32'hFFFF_FFFC;
    tick();
    total++;
    if (cur !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_setup2: got %h expected %h", cur, 32'hFFFF_FFFC);
    end
    rel = 1'b1; nxt = 32'h0000_0008;
    tick();
    total++;
    if (cur !== 32'h0000_0004) begin
      bad++;
      $display("FAIL wrap_rel_fwd: got %h expected %h", cur, 32'h0000_0004);
    end
    // A relative -16 from 0x4 wraps below zero to 0xFFFF_FFF4.
    nxt = 32'hFFFF_FFF0;
    tick();
    total++;
    if (cur !== 32'hFFFF_FFF4) begin
      bad++;
      $display("FAIL wrap_rel_back: got %h expected %h", cur, 32'hFFFF_FFF4);
    end
    // A misaligned absolute target passes through without masking.
    rel = 1'b0; nxt = 32'h0000_2002;
    tick();
    total++;
    if (cur !== 32'h0000_2002) begin
      bad++;
      $display("FAIL misaligned: got %h expected %h", cur, 32'h0000_2002);
    end
    jmp = 1'b0;
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; jmp = 1'b1; rel = 1'b0; nxt = 32'h0000_2000;
    tick();
    total++;
    if (cur !== 32'h0000_0000) begin
      bad++;
      $display("FAIL rst_over_abs: got %h expected %h", cur, 32'h0000_0000);
    end
    rst = 1'b0; jmp = 1'b0; rel = 1'b1; nxt = 32'hDEAD_BEEF;
    tick();
    total++;
    if (cur !== 32'h0000_0004) begin
      bad++;
      $display("FAIL rel_no_jmp1: got %h expected %h", cur, 32'h0000_0004);
    end
    tick();
    total++;
    if (cur !== 32'h0000_0008) begin
      bad++;
      $display("FAIL rel_no_jmp2: got %h expected %h", cur, 32'h0000_0008);
    end
    // A reset that arrives with a pending relative jump also wins.
    rst = 1'b1; jmp = 1'b1; rel = 1'b1; nxt = 32'h0000_0100;
    tick();
    total++;
    if (cur !== 32'h0000_0000) begin
      bad++;
      $display("FAIL rst_over_rel: got %h expected %h", cur, 32'h0000_0000);
    end
    rst = 1'b0; jmp = 1'b0; rel = 1'b0; nxt = 32'h0;
    tick();
    total++;
    if (cur !== 32'h0000_0004) begin
      bad++;
      $display("FAIL rst_resume: got %h expected %h", cur, 32'h0000_0004);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    jmp   = 1'b0;
    rel   = 1'b0;
    nxt   = 32'h0;
    #1;
    test_reset();
    test_abs_jump();
    test_rel_backward();
    test_rel_forward_zero();
    test_wrap();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
